pipelined_seg_adder: RTL and testbench

//   Parametrised, pipelined carry-segmented adder/subtractor. It is the next-generation

---
 rtl/pipelined_seg_adder.sv | 196 +++++++++++++++++++
 tb/tb_pipelined_seg_adder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_seg_adder.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_seg_adder
// Description : Parametrised, pipelined, carry-segmented adder/subtractor.
//               Operands are split into SEG-bit segments. Each segment is
//               summed in its own pipeline stage, so the clock rate is set
//               by one SEG-bit ripple. The carry between segments is
//               registered between stages.
//               Latency is NSEG cycles, and one result can be produced per
//               cycle. Valid/ready handshakes are used on both sides.
//               WIDTH must be an integer multiple of SEG.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand set {a,b,cin,sub} valid this cycle
//   in_ready   out  1      block accepts operands this cycle
//   a          in   WIDTH  augend / minuend
//   b          in   WIDTH  addend / subtrahend
//   cin        in   1      carry-in (ignored in subtract mode)
//   sub        in   1      1: a - b ; 0: a + b + cin
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   sum        out  WIDTH  result modulo 2^WIDTH
//   cout       out  1      carry out of the MSB (subtract: 1 = no borrow)
//   ovf        out  1      two's-complement signed overflow
// ============================================================================
module pipelined_seg_adder #(
   parameter int WIDTH = 32,
   parameter int SEG   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   // Number of pipeline stages; equals the latency in cycles.
   localparam int NSEG = WIDTH / SEG;

   // -------------------------------------------------------------------------
   // Input conditioning
   // -------------------------------------------------------------------------
   // Subtraction is folded into the operands here, so the mode bit never
   // travels down the pipe: a - b == a + ~b + 1.
   logic [WIDTH-1:0] w_beff;
   logic             w_c0;
   logic             w_en;

   assign w_beff = sub ? ~b : b;
   assign w_c0   = sub | cin;

   // -------------------------------------------------------------------------
   // Stage register outputs
   // -------------------------------------------------------------------------
   // Each stage exports its registers through these arrays so the next stage
   // can pick them up without hierarchical references.
   logic             w_vld_q [NSEG];
   logic             w_cy_q  [NSEG];
   logic [WIDTH-1:0] w_a_q   [NSEG];
   logic [WIDTH-1:0] w_b_q   [NSEG];
   logic [WIDTH-1:0] w_sum_q [NSEG];

   // Overflow inputs, formed at the last stage where the operand MSBs live.
   logic             w_ovf_nxt;
   logic             w_ld_last;
   logic             r_ovf;

   // Global advance enable. The pipe moves only when the output register is
   // empty or being drained. Every stage shares this enable, so a stall
   // freezes the whole pipe.
   assign w_en     = ~w_vld_q[NSEG-1] | out_ready;
   assign in_ready = w_en;

   // -------------------------------------------------------------------------
   // Pipeline stages
   // -------------------------------------------------------------------------
   // Stage k adds the lowest segment of its incoming operand words.
   // The operand words are skew registers. They are shifted right by SEG at
   // every stage, so the segment needed next is always at the bottom. Only
   // not-yet-consumed bits remain; the vacated top bits are constant zero.
   // This also means the operand MSBs arrive at the last stage's segment
   // MSB, which the overflow logic relies on.
   //
   // The partial sum is a deskew register filled from the top. Each stage
   // shifts the previous partial sum right by SEG and inserts its own
   // segment at the top. After NSEG stages, segment 0 has reached bit 0.
   genvar k;
   generate
      for (k = 0; k < NSEG; k++) begin : g_stage
         logic [WIDTH-1:0] w_a_in;
         logic [WIDTH-1:0] w_b_in;
         logic [WIDTH-1:0] w_sum_in;
         logic             w_c_in;
         logic             w_v_in;
         logic [SEG:0]     w_add;
         logic [WIDTH-1:0] w_sum_nxt;

         logic             r_vld;
         logic             r_cy;
         logic [WIDTH-1:0] r_a;
         logic [WIDTH-1:0] r_b;
         logic [WIDTH-1:0] r_sum;

         if (k == 0) begin : g_head
            assign w_a_in   = a;
            assign w_b_in   = w_beff;
            assign w_sum_in = '0;
            assign w_c_in   = w_c0;
            assign w_v_in   = in_valid;
         end else begin : g_body
            assign w_a_in   = w_a_q[k-1];
            assign w_b_in   = w_b_q[k-1];
            assign w_sum_in = w_sum_q[k-1];
            assign w_c_in   = w_cy_q[k-1];
            assign w_v_in   = w_vld_q[k-1];
         end

         // One SEG-bit ripple; bit SEG is the carry into the next stage.
         assign w_add = {1'b0, w_a_in[SEG-1:0]}
                      + {1'b0, w_b_in[SEG-1:0]}
                      + {{SEG{1'b0}}, w_c_in};

         assign w_sum_nxt = (w_sum_in >> SEG)
                          | (WIDTH'(w_add[SEG-1:0]) << (WIDTH - SEG));

         // The valid bit always follows the pipe, so bubbles propagate.
         // Data only loads behind a valid operand. This keeps bubble slots
         // from toggling the wide registers.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_vld <= 1'b0;
               r_cy  <= 1'b0;
               r_a   <= '0;
               r_b   <= '0;
               r_sum <= '0;
            end else if (w_en) begin
               r_vld <= w_v_in;
               if (w_v_in) begin
                  r_cy  <= w_add[SEG];
                  r_a   <= w_a_in >> SEG;
                  r_b   <= w_b_in >> SEG;
                  r_sum <= w_sum_nxt;
               end
            end
         end

         assign w_vld_q[k] = r_vld;
         assign w_cy_q[k]  = r_cy;
         assign w_a_q[k]   = r_a;
         assign w_b_q[k]   = r_b;
         assign w_sum_q[k] = r_sum;

         // The last stage holds the original operand MSBs at its segment MSB.
         // Signed overflow occurs when both operands have the same sign and
         // the sum has the other sign.
         if (k == NSEG - 1) begin : g_tail
            assign w_ovf_nxt = (w_a_in[SEG-1] == w_b_in[SEG-1])
                             & (w_add[SEG-1] != w_a_in[SEG-1]);
            assign w_ld_last = w_v_in;
         end
      end
   endgenerate

   // The overflow flag is registered alongside the last stage, using the
   // same enable and valid gating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_en && w_ld_last) begin
         r_ovf <= w_ovf_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   // The last stage register is the output register. It holds while
   // out_valid && !out_ready, because w_en is low then.
   assign out_valid = w_vld_q[NSEG-1];
   assign sum       = w_sum_q[NSEG-1];
   assign cout      = w_cy_q[NSEG-1];
   assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_seg_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_seg_adder
// Description : Directed self-checking bench for pipelined_seg_adder
//               (WIDTH=32, SEG=8, latency 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_seg_adder;

   localparam int WIDTH = 32;
   localparam int SEG   = 8;

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b1;
   logic             in_valid  = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] a         = '0;
   logic [WIDTH-1:0] b         = '0;
   logic             cin       = 1'b0;
   logic             sub       = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b1;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   int n_cmp = 0;
   int n_bad = 0;

   logic [33:0] exq[$];

   always #5 clk = ~clk;

   pipelined_seg_adder #(
      .WIDTH (WIDTH),
      .SEG   (SEG)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference result {ovf, cout, sum} from full-width arithmetic.
   function automatic logic [33:0] model(input logic [31:0] fa, input logic [31:0] fb,
                                         input logic fc, input logic fs);
      logic [31:0] be;
      logic [32:0] t;
      logic        v;
      be = fs ? ~fb : fb;
      t  = {1'b0, fa} + {1'b0, be} + {32'd0, (fs ? 1'b1 : fc)};
      v  = (fa[31] == be[31]) && (t[31] != fa[31]);
      return {v, t[32], t[31:0]};
   endfunction

   task automatic new_op();
      a        = $urandom;
      b        = $urandom;
      cin      = 1'($urandom_range(0, 1));
      sub      = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
   endtask

   // One isolated operation with an empty pipe, checking the exact latency.
   task automatic run_one(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                          input logic tc, input logic ts,
                          input logic [31:0] es, input logic ec, input logic eo);
      a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
      #1;
      check({tag, "/in_ready"}, in_ready, 1);
      step();                       // accepted on this edge
      in_valid = 1'b0;
      step();
      step();
      check({tag, "/early"}, out_valid, 0);
      step();                       // fourth edge after acceptance
      check({tag, "/valid"}, out_valid, 1);
      check({tag, "/sum"},   sum,  es);
      check({tag, "/cout"},  cout, ec);
      check({tag, "/ovf"},   ovf,  eo);
      step();
      check({tag, "/drained"}, out_valid, 0);
   endtask

   initial begin : main
      int          sent;
      int          got;
      logic        do_in;
      logic        do_out;
      logic [33:0] held;

      // ---------------- reset state ----------------
      #2 rst_n = 1'b0;
      #1;
      check("reset_valid", out_valid, 0);
      check("reset_sum",   sum,  0);
      check("reset_cout",  cout, 0);
      check("reset_ovf",   ovf,  0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("reset_in_ready", in_ready, 1);

      // ---------------- directed vectors ----------------
      run_one("add_wrap",   32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
      run_one("sub_neg",    32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0);
      run_one("add_ovf",    32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
      run_one("sub_ovf",    32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1);
      run_one("cross_seg",  32'h00FF00FF, 32'h00010001, 1'b1, 1'b0, 32'h01000101, 1'b0, 1'b0);
      run_one("sub_cin_ig", 32'h00000010, 32'h00000003, 1'b1, 1'b1, 32'h0000000D, 1'b1, 1'b0);

      // ---------------- 8 back-to-back ops ----------------
      exq.delete();
      for (int c = 0; c < 14; c++) begin
         if (c < 8) begin
            new_op();
            exq.push_back(model(a, b, cin, sub));
         end else begin
            in_valid = 1'b0;
         end
         step();
         if (c >= 3 && c <= 10) begin
            check("b2b_valid", out_valid, 1);
            if (exq.size() > 0) check("b2b_result", {ovf, cout, sum}, exq.pop_front());
         end else begin
            check("b2b_idle", out_valid, 0);
         end
      end
      check("b2b_leftover", exq.size(), 0);

      // ---------------- backpressure with a full pipe ----------------
      exq.delete();
      sent = 0;
      got  = 0;
      new_op();
      for (int c = 0; c < 60 && got < 10; c++) begin
         out_ready = !(c >= 6 && c <= 8);
         #1;
         if (c >= 6 && c <= 8) begin
            check("bp_in_ready",  in_ready,  0);
            check("bp_out_valid", out_valid, 1);
            if (c == 6) held = {ovf, cout, sum};
            else        check("bp_hold", {ovf, cout, sum}, held);
         end
         do_out = out_valid && out_ready;
         do_in  = in_valid && in_ready;
         if (do_out) begin
            if (exq.size() > 0) check("bp_result", {ovf, cout, sum}, exq.pop_front());
            else                check("bp_extra", 1, 0);
            got++;
         end
         if (do_in) exq.push_back(model(a, b, cin, sub));
         step();
         if (do_in) begin
            sent++;
            if (sent < 10) new_op();
            else           in_valid = 1'b0;
         end
      end
      out_ready = 1'b1;
      check("bp_count",    got, 10);
      check("bp_leftover", exq.size(), 0);

      // ---------------- async reset mid-stream ----------------
      for (int c = 0; c < 5; c++) begin
         new_op();
         step();
      end
      in_valid = 1'b0;
      check("rst_pre_valid", out_valid, 1);
      #3 rst_n = 1'b0;              // between clock edges
      #1;
      check("rst_async_valid", out_valid, 0);
      check("rst_async_sum",   sum,  0);
      check("rst_async_cout",  cout, 0);
      check("rst_async_ovf",   ovf,  0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step();
         check("rst_no_stale", out_valid, 0);
      end
      check("rst_in_ready", in_ready, 1);
      run_one("post_rst", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
